bulk_in_packetiser: RTL and testbench
=====================================

BULK_IN_PACKETISER -- requirements
Module: bulk_in_packetiser

Interface
REQ-001 Parameter: MAX_PACKET_LENGTH, default 512, USB BULK IN max packet size in bytes; legal values are powers of 2 from 8 to 1024.
REQ-002 Port: clock  in  1  single clock for all logic, rising-edge.
REQ-003 Port: arst_n  in  1  reset, asynchronous assert and active-low, synchronous release by the integrator.
REQ-004 Port: s_tvalid/s_tready/s_tlast  in/out/in  1 each  32-bit word-stream handshake; s_tlast marks end-of-frame.
REQ-005 Port: s_tkeep  in  4  byte enables; bit i qualifies s_tdata[8i+7:8i].
REQ-006 Port: s_tdata  in  32  word data, little-endian byte order.
REQ-007 Port: m_tvalid/m_tready/m_tlast  out/in/out  1 each  byte-stream handshake to the USB BULK IN endpoint; m_tlast ends a USB packet.
REQ-008 Port: m_tkeep  out  1  equals m_tvalid.
REQ-009 Port: m_tdata  out  8  byte data.
REQ-010 Port: err_o  out  1  sticky flag for an illegal s_tkeep; cleared only by reset.

Function
REQ-011 Word hold register: the block SHALL hold exactly one word. Flags: held, byte index idx[1:0], byte count n (1..4), frame-last flag.
REQ-012 States:
- EMPTY (held=0)
- SEND (held=1)
- EMPTY->SEND on an accepted word with n>=1.
- SEND->EMPTY when the last byte transfers and no new word is accepted in the same cycle.
- SEND->SEND when the last byte transfers and a new word is accepted in the same cycle.
REQ-013 s_tready SHALL equal ~held | (m_tready & idx==n-1), combinationally. A new word can therefore be accepted in the same cycle as the final byte of the current word.
REQ-014 m_tvalid SHALL equal held. m_tdata SHALL be byte idx of the held word.
REQ-015 Latency: byte 0 SHALL appear on m_tdata in the cycle after the word is accepted. Sustained throughput SHALL be 1 byte/cycle with no bubbles between back-to-back words.
REQ-016 idx SHALL increment only on m_tvalid & m_tready. m_tdata and m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-017 Byte count: n = index of highest set s_tkeep bit + 1.
- Legal s_tkeep values: 4'b0001, 4'b0011, 4'b0111, 4'b1111.
- 4'b1111 is the only legal value when s_tlast=0.
- Any other value SHALL set err_o and is still emitted using n.
REQ-018 A word with s_tkeep=4'b0000 SHALL be accepted and dropped (no state change), and SHALL set err_o.
REQ-019 Packet counter pc (log2(MAX_PACKET_LENGTH) bits) SHALL count transferred bytes. It SHALL reset to 0 after every transfer with m_tlast=1.
REQ-020 m_tlast SHALL be 1 when either condition holds:
- (idx==n-1 and the held word had s_tlast=1), or
- pc==MAX_PACKET_LENGTH-1.
REQ-021 A frame whose length is an exact multiple of MAX_PACKET_LENGTH SHALL produce a single m_tlast on its final byte. No zero-length packet SHALL be generated.
REQ-022 s_tdata, s_tkeep and s_tlast SHALL be ignored when s_tvalid=0 or s_tready=0.

Reset
REQ-023 While arst_n=0:
- m_tvalid=0, m_tlast=0, m_tdata=8'h00, s_tready=0.
- held=0, idx=0, pc=0, err_o=0.
REQ-024 On the first clock edge after arst_n rises, s_tready SHALL be 1.
REQ-025 Reset asserted mid-word or mid-packet SHALL discard the held word and pc immediately. No partial packet SHALL resume after release.

Verification
REQ-026 Single word 32'h44332211, tkeep=4'hF, tlast=1, m_tready=1 -> bytes 11,22,33,44 on 4 consecutive cycles starting 1 cycle after acceptance; m_tlast only on 44; s_tready=1 in the 44 cycle.
REQ-027 Frame of 256 words (1024 bytes), MAX_PACKET_LENGTH=512, m_tready=1 -> 1024 bytes with no gaps; m_tlast on byte 511 and byte 1023 only; the frame's final word is accepted in the same cycle as the last byte of the word before it.
REQ-028 Final word with tkeep=4'b0011, tlast=1, after 3 full words -> 14 bytes out; m_tlast on byte 13; err_o=0.
REQ-029 Random m_tready (50%) over a 3000-byte frame -> output byte sequence equals input; m_tdata and m_tlast hold while stalled; m_tlast after every 512th byte and on byte 2999.
REQ-030 Illegal inputs -> err_o rises and stays 1:
- tkeep=4'b0101, tlast=0 -> 3 bytes emitted.
- tkeep=4'b0000 -> word consumed, no bytes emitted.
REQ-031 Reset pulse after byte 2 of a word -> m_tvalid=0 immediately; after release the next word starts at idx 0 with pc=0.

Source files
------------

// File: rtl/bulk_in_packetiser.sv
// rtl/bulk_in_packetiser.sv - 32-bit word stream to USB BULK IN byte stream packetiser
// Holds one word, emits its valid bytes LSB first and cuts packets at frame end or MAX_PACKET_LENGTH.
module bulk_in_packetiser #(
  parameter int MAX_PACKET_LENGTH = 512
) (
  input  logic        clock,
  input  logic        arst_n,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [3:0]  s_tkeep,
  input  logic [31:0] s_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tkeep,
  output logic [7:0]  m_tdata,
  output logic        err_o
);

  localparam int PCW = $clog2(MAX_PACKET_LENGTH);
  localparam logic [PCW-1:0] PC_MAX = PCW'(MAX_PACKET_LENGTH - 1);

  typedef enum logic {EMPTY, SEND} state_t;

  state_t         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [1:0]     nm1_q, nm1_d;
  logic           last_q, last_d;
  logic [31:0]    data_q, data_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic           err_q, err_d;

  logic [1:0] in_nm1;
  logic       keep_zero;
  logic       keep_legal;
  logic       last_byte;
  logic       accept;
  logic       xfer;

  // n-1 taken from the highest set keep bit; holes below it are still emitted
  always_comb begin
    in_nm1 = 2'd0;
    casez (s_tkeep)
      4'b1???: in_nm1 = 2'd3;
      4'b01??: in_nm1 = 2'd2;
      4'b001?: in_nm1 = 2'd1;
      default: in_nm1 = 2'd0;
    endcase
  end

  assign keep_zero  = (s_tkeep == 4'b0000);
  assign keep_legal = s_tlast ? (s_tkeep == 4'b0001 || s_tkeep == 4'b0011 ||
                                 s_tkeep == 4'b0111 || s_tkeep == 4'b1111)
                              : (s_tkeep == 4'b1111);

  assign last_byte = (idx_q == nm1_q);
  assign m_tvalid  = (state_q == SEND);
  assign m_tkeep   = m_tvalid;
  assign s_tready  = arst_n & (~m_tvalid | (m_tready & last_byte));
  assign accept    = s_tvalid & s_tready;
  assign xfer      = m_tvalid & m_tready;
  assign m_tlast   = m_tvalid & ((last_byte & last_q) | (pc_q == PC_MAX));
  assign err_o     = err_q;

  always_comb begin
    m_tdata = 8'h00;
    if (m_tvalid) begin
      case (idx_q)
        2'd0:    m_tdata = data_q[7:0];
        2'd1:    m_tdata = data_q[15:8];
        2'd2:    m_tdata = data_q[23:16];
        default: m_tdata = data_q[31:24];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nm1_d   = nm1_q;
    last_d  = last_q;
    data_d  = data_q;
    pc_d    = pc_q;
    err_d   = err_q;
    if (xfer) begin
      pc_d = m_tlast ? '0 : pc_q + 1'b1;
      if (last_byte) begin
        state_d = EMPTY;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
    // A new word can only arrive when the hold register is empty or draining its last byte
    if (accept) begin
      if (keep_zero) begin
        err_d = 1'b1;
      end else begin
        state_d = SEND;
        idx_d   = 2'd0;
        nm1_d   = in_nm1;
        last_d  = s_tlast;
        data_d  = s_tdata;
        if (!keep_legal) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
      idx_q   <= 2'd0;
      nm1_q   <= 2'd0;
      last_q  <= 1'b0;
      data_q  <= 32'h0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nm1_q   <= nm1_d;
      last_q  <= last_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bulk_in_packetiser.sv
// tb/tb_bulk_in_packetiser.sv - directed self-checking bench for bulk_in_packetiser
module tb_bulk_in_packetiser;

  logic        clock = 1'b0;
  logic        arst_n;
  logic        s_tvalid, s_tready, s_tlast;
  logic [3:0]  s_tkeep;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tkeep;
  logic [7:0]  m_tdata;
  logic        err_o;

  bulk_in_packetiser #(.MAX_PACKET_LENGTH(512)) dut (
    .clock(clock), .arst_n(arst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tkeep(s_tkeep), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tkeep(m_tkeep), .m_tdata(m_tdata), .err_o(err_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  logic [31:0] wd_q[$];
  logic [3:0]  wk_q[$];
  logic        wl_q[$];
  logic [8:0]  exp_q[$];
  int mpc = 0;

  int nout, first_acc, first_out, last_out;
  logic sready_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Queue one input word plus the bytes it must produce, with packet cuts every 512 bytes
  task automatic push_word(input logic [31:0] d, input logic [3:0] k, input logic l, input int nb);
    logic lst;
    wd_q.push_back(d);
    wk_q.push_back(k);
    wl_q.push_back(l);
    for (int i = 0; i < nb; i++) begin
      lst = ((i == nb - 1) && l) || (mpc == 511);
      exp_q.push_back({lst, d[8*i +: 8]});
      mpc = lst ? 0 : mpc + 1;
    end
  endtask

  task automatic run(input bit rnd, input int stop_after);
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [8:0] prev = '0;
    logic [8:0] e;
    nout = 0; first_acc = -1; first_out = -1; last_out = -1; sready_last = 1'b0;
    while ((wd_q.size() > 0 || exp_q.size() > 0) && (stop_after == 0 || nout < stop_after)) begin
      if (cyc > 20000) begin
        chk("timeout", cyc, 20000);
        break;
      end
      s_tvalid = (wd_q.size() > 0);
      s_tdata  = s_tvalid ? wd_q[0] : 32'h0;
      s_tkeep  = s_tvalid ? wk_q[0] : 4'h0;
      s_tlast  = s_tvalid ? wl_q[0] : 1'b0;
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clock);
      if (prev_stall) chk("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev});
      prev_stall = m_tvalid && !m_tready;
      prev = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_byte", {m_tlast, m_tdata}, 32'h1ff);
        else begin
          e = exp_q.pop_front();
          chk("byte", {m_tlast, m_tdata}, e);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        sready_last = s_tready;
        nout++;
      end
      if (s_tvalid && s_tready) begin
        void'(wd_q.pop_front());
        void'(wk_q.pop_front());
        void'(wl_q.pop_front());
        if (first_acc < 0) first_acc = cyc;
      end
      @(posedge clock);
      #1;
      cyc++;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    s_tvalid = 1'b0;
    wd_q.delete(); wk_q.delete(); wl_q.delete(); exp_q.delete();
    mpc = 0;
    @(negedge clock);
    arst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    arst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 4'h0;
    s_tdata = 32'h0; m_tready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_err", err_o, 0);
    arst_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_s_tready", s_tready, 1);

    // single word
    push_word(32'h44332211, 4'hF, 1'b1, 4);
    run(1'b0, 0);
    chk("w1_count", nout, 4);
    chk("w1_latency", first_out - first_acc, 1);
    chk("w1_gapless", last_out - first_out, 3);
    chk("w1_sready_last", sready_last, 1);

    // short final word
    for (int i = 0; i < 3; i++) push_word(32'hA0A1A2A3 + 32'(i), 4'hF, 1'b0, 4);
    push_word(32'h0000BEEF, 4'b0011, 1'b1, 2);
    run(1'b0, 0);
    chk("short_count", nout, 14);
    chk("short_err", err_o, 0);

    // 1024-byte frame, two packets, no bubbles
    for (int i = 0; i < 256; i++)
      push_word({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 4'hF, i == 255, 4);
    run(1'b0, 0);
    chk("k1_count", nout, 1024);
    chk("k1_gapless", last_out - first_out, 1023);

    // 3000-byte frame under random backpressure
    for (int i = 0; i < 750; i++)
      push_word($urandom(), 4'hF, i == 749, 4);
    run(1'b1, 0);
    chk("rnd_count", nout, 3000);

    // all-zero keep is swallowed
    do_reset();
    push_word(32'h12345678, 4'b0000, 1'b1, 0);
    run(1'b0, 0);
    chk("k0_err", err_o, 1);
    chk("k0_count", nout, 0);
    chk("k0_idle", m_tvalid, 0);

    // holey keep mid-frame
    do_reset();
    chk("hole_err_pre", err_o, 0);
    push_word(32'h33221100, 4'b0101, 1'b0, 3);
    push_word(32'h77665544, 4'hF, 1'b1, 4);
    run(1'b0, 0);
    chk("hole_err", err_o, 1);
    chk("hole_count", nout, 7);

    // reset mid-word, mid-packet
    do_reset();
    for (int i = 0; i < 129; i++) push_word(32'h01020304 * 32'(i + 1), 4'hF, i == 128, 4);
    run(1'b0, 510);
    arst_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tlast", m_tlast, 0);
    chk("mid_rst_err", err_o, 0);
    do_reset();
    push_word(32'hDDCCBBAA, 4'hF, 1'b1, 4);
    run(1'b0, 0);
    chk("post_rst_count", nout, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
